// File: rtl/chan_sel_reg_pkg.sv
// Shared definitions for the CH-way registered channel selector.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents: mode encodings, select-width derivation, and the bit offset
// of channel k inside the flattened per-channel data bus.
package chan_sel_reg_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Width of a channel index. CH is at least 2, so the result is at least 1.
  function automatic int sel_width(input int ch);
    return (ch > 2) ? $clog2(ch) : 1;
  endfunction

  // LSB position of channel k in a bus of CH channels of n bits each.
  function automatic int chan_lsb(input int k, input int n);
    return k * n;
  endfunction

endpackage

// File: rtl/chan_sel_reg_rr.sv
// Round-robin request scanner: finds the first requester at or after ptr.
// Latency: purely combinational, no state (the pointer is owned by the caller).
// Backpressure: en = 0 suppresses gnt; idx/any still report the candidate.
//
// Ports:
//   req [CH]  per-channel request       ptr [PW]  scan start channel (< CH)
//   en        allow a grant this cycle  gnt [CH]  one-hot grant, or zero
//   idx [PW]  winning channel index     any       a requester was found
module rr_arbiter
  import chan_sel_reg_pkg::*;
#(
  parameter int CH = 4,
  parameter int PW = sel_width(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [CH-1:0] gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic          hit;
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] scan;

  // Walk ptr, ptr+1, ... (mod CH); the first asserted request wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    scan    = '0;
    for (int i = 0; i < CH; i++) begin
      scan = PW'((int'(ptr) + i) % CH);
      if (!hit && req[scan]) begin
        hit     = 1'b1;
        hit_idx = scan;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (en && hit) begin
      gnt[hit_idx] = 1'b1;
    end
  end

  assign idx = hit_idx;
  assign any = hit;

endmodule

// File: rtl/chan_sel_reg.sv
// CH-way channel selector (explicit select or round-robin) with a registered output.
// Latency: 1 cycle from the GNT cycle to out_vld; sustains 1 word per cycle.
// Backpressure: out_vld & !out_rdy blocks grants and freezes out, out_ch and rr_ptr.
//
// Ports:
//   CLK, CLR        clock (rising) / asynchronous active-high reset
//   D [CH*N]        flattened channel data, channel k = D[k*N +: N]
//   REQ [CH]        per-channel data valid
//   MODE            0 = select by SEL, 1 = round-robin over REQ
//   SEL [SELW]      channel used in select mode (values >= CH never grant)
//   EN              global grant enable
//   GNT [CH]        one-hot grant in the load cycle; producer treats it as consumed
//   out [N], out_vld, out_ch [SELW]   held word, its valid and source channel
//   out_rdy         downstream accepts out when out_vld & out_rdy
module chan_sel_reg
  import chan_sel_reg_pkg::*;
#(
  parameter int N    = 5,
  parameter int CH   = 4,
  parameter int SELW = sel_width(CH)
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [CH*N-1:0]     D,
  input  logic [CH-1:0]       REQ,
  input  logic                MODE,
  input  logic [SELW-1:0]     SEL,
  input  logic                EN,
  output logic [CH-1:0]       GNT,
  output logic [N-1:0]        out,
  output logic                out_vld,
  output logic [SELW-1:0]     out_ch,
  input  logic                out_rdy
);

  logic [N-1:0]    out_q, out_d;
  logic            out_vld_q, out_vld_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;

  logic            space;
  logic            grant_ok;
  logic            rr_mode;

  logic [CH-1:0]   arb_gnt;
  logic [SELW-1:0] arb_idx;
  logic            arb_any;

  logic            dir_any;
  logic [CH-1:0]   dir_gnt;

  logic            cand_any;
  logic [SELW-1:0] cand_idx;
  logic            load;

  logic [N-1:0]    chan_dat [CH];

  for (genvar k = 0; k < CH; k++) begin : g_chan
    assign chan_dat[k] = D[chan_lsb(k, N) +: N];
  end

  // The register can take a new word if it is empty or being drained now.
  // CLR also masks grants so GNT reads zero for the whole reset interval.
  assign space    = !out_vld_q || out_rdy;
  assign grant_ok = EN && space && !CLR;
  assign rr_mode  = (MODE == MODE_RR);

  rr_arbiter #(
    .CH (CH),
    .PW (SELW)
  ) u_rr (
    .req (REQ),
    .ptr (rr_ptr_q),
    .en  (grant_ok && rr_mode),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Select mode: SEL beyond the last channel (CH not a power of 2) is never a candidate.
  always_comb begin
    dir_any = 1'b0;
    dir_gnt = '0;
    if (int'(SEL) < CH) begin
      dir_any = REQ[SEL];
    end
    if (grant_ok && !rr_mode && dir_any) begin
      dir_gnt[SEL] = 1'b1;
    end
  end

  assign cand_any = rr_mode ? arb_any : dir_any;
  assign cand_idx = rr_mode ? arb_idx : SEL;
  assign load     = grant_ok && cand_any;
  assign GNT      = rr_mode ? arb_gnt : dir_gnt;

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    out_ch_d  = out_ch_q;
    rr_ptr_d  = rr_ptr_q;
    if (load) begin
      out_d     = chan_dat[cand_idx];
      out_ch_d  = cand_idx;
      out_vld_d = 1'b1;
      // Fairness: next scan starts just past the channel served now.
      if (rr_mode) begin
        rr_ptr_d = (int'(cand_idx) == CH - 1) ? '0 : cand_idx + 1'b1;
      end
    end else if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      out_ch_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      out_ch_q  <= out_ch_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign out     = out_q;
  assign out_vld = out_vld_q;
  assign out_ch  = out_ch_q;

endmodule

// File: tb/tb_chan_sel_reg.sv
// Bench for chan_sel_reg: a CH=4 and a CH=5 instance driven side by side,
// checked every cycle against a behavioural model plus directed literal checks.
module tb_chan_sel_reg;

  logic clk;
  logic clr;

  // Per-instance stimulus, sized for the widest instance (u=0: CH=4, u=1: CH=5).
  logic [24:0] d_v    [2];
  logic [4:0]  req_v  [2];
  logic [2:0]  sel_v  [2];
  logic        mode_v [2];
  logic        en_v   [2];
  logic        rdy_v  [2];

  logic [3:0] gnt4;
  logic [4:0] out4;
  logic       vld4;
  logic [1:0] ch4;
  logic [4:0] gnt5;
  logic [4:0] out5;
  logic       vld5;
  logic [2:0] ch5;

  logic [4:0] dut_gnt [2];
  logic [4:0] dut_out [2];
  logic       dut_vld [2];
  logic [2:0] dut_ch  [2];

  assign dut_gnt[0] = {1'b0, gnt4};
  assign dut_gnt[1] = gnt5;
  assign dut_out[0] = out4;
  assign dut_out[1] = out5;
  assign dut_vld[0] = vld4;
  assign dut_vld[1] = vld5;
  assign dut_ch[0]  = {1'b0, ch4};
  assign dut_ch[1]  = ch5;

  chan_sel_reg #(.N(5), .CH(4)) dut4 (
    .CLK     (clk),
    .CLR     (clr),
    .D       (d_v[0][19:0]),
    .REQ     (req_v[0][3:0]),
    .MODE    (mode_v[0]),
    .SEL     (sel_v[0][1:0]),
    .EN      (en_v[0]),
    .GNT     (gnt4),
    .out     (out4),
    .out_vld (vld4),
    .out_ch  (ch4),
    .out_rdy (rdy_v[0])
  );

  chan_sel_reg #(.N(5), .CH(5)) dut5 (
    .CLK     (clk),
    .CLR     (clr),
    .D       (d_v[1]),
    .REQ     (req_v[1]),
    .MODE    (mode_v[1]),
    .SEL     (sel_v[1]),
    .EN      (en_v[1]),
    .GNT     (gnt5),
    .out     (out5),
    .out_vld (vld5),
    .out_ch  (ch5),
    .out_rdy (rdy_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         ch_of [2] = '{4, 5};
  logic [4:0] m_out [2];
  logic       m_vld [2];
  int         m_ch  [2];
  int         m_ptr [2];

  function automatic logic req_bit(input int u, input int k);
    logic [4:0] r;
    r = req_v[u] >> k;
    return r[0];
  endfunction

  // Channel that is granted this cycle, or -1 when nothing is granted.
  function automatic int cand(input int u);
    int c;
    c = ch_of[u];
    if (clr || !en_v[u]) return -1;
    if (m_vld[u] && !rdy_v[u]) return -1;
    if (mode_v[u] == 1'b0) begin
      if (int'(sel_v[u]) < c && req_bit(u, int'(sel_v[u]))) return int'(sel_v[u]);
      return -1;
    end
    for (int i = 0; i < c; i++) begin
      if (req_bit(u, (m_ptr[u] + i) % c)) return (m_ptr[u] + i) % c;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge clr) begin : model
    int k;
    for (int u = 0; u < 2; u++) begin
      if (clr) begin
        m_out[u] <= '0;
        m_vld[u] <= 1'b0;
        m_ch[u]  <= 0;
        m_ptr[u] <= 0;
      end else begin
        k = cand(u);
        if (k >= 0) begin
          m_out[u] <= 5'(d_v[u] >> (k * 5));
          m_ch[u]  <= k;
          m_vld[u] <= 1'b1;
          if (mode_v[u]) m_ptr[u] <= (k + 1) % ch_of[u];
        end else if (m_vld[u] && rdy_v[u]) begin
          m_vld[u] <= 1'b0;
        end
      end
    end
  end

  // Single compare process: every negedge, both instances against the model.
  always @(negedge clk) begin : cmp
    int k;
    int eg;
    for (int u = 0; u < 2; u++) begin
      k  = cand(u);
      eg = (k >= 0) ? (1 << k) : 0;
      chk($sformatf("u%0d_gnt", u), int'(dut_gnt[u]), eg);
      chk($sformatf("u%0d_gnt_onehot0", u), int'($onehot0(dut_gnt[u])), 1);
      chk($sformatf("u%0d_out_vld", u), int'(dut_vld[u]), int'(m_vld[u]));
      chk($sformatf("u%0d_out", u), int'(dut_out[u]), int'(m_out[u]));
      chk($sformatf("u%0d_out_ch", u), int'(dut_ch[u]), m_ch[u]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_seq [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    clr = 1'b0;
    for (int u = 0; u < 2; u++) begin
      d_v[u] = '0; req_v[u] = '0; sel_v[u] = '0;
      mode_v[u] = 1'b0; en_v[u] = 1'b0; rdy_v[u] = 1'b0;
    end
    #1 clr = 1'b1;
    #2;
    chk("reset_out4", int'(out4), 0);
    chk("reset_vld4", int'(vld4), 0);
    chk("reset_ch4", int'(ch4), 0);
    chk("reset_gnt4", int'(gnt4), 0);
    chk("reset_vld5", int'(vld5), 0);
    #9 clr = 1'b0;

    // Select mode, SEL = 2.
    next_cyc();
    mode_v[0] = 1'b0; sel_v[0] = 3'd2; req_v[0] = 5'b00100;
    d_v[0] = {5'h00, 5'h1f, 5'h13, 5'h0a, 5'h05};
    rdy_v[0] = 1'b1; en_v[0] = 1'b1;
    @(negedge clk);
    chk("direct_gnt", int'(gnt4), 4'b0100);
    next_cyc();
    req_v[0] = 5'b00000;
    @(negedge clk);
    chk("direct_out", int'(out4), 5'h13);
    chk("direct_ch", int'(ch4), 2);
    chk("direct_vld", int'(vld4), 1);

    // Round-robin, all requesting: one word per cycle in channel order.
    next_cyc();
    mode_v[0] = 1'b1; req_v[0] = 5'b01111;
    d_v[0] = {5'd0, 5'd4, 5'd3, 5'd2, 5'd1};
    @(negedge clk);
    chk("rr_first_gnt", int'(gnt4), 4'b0001);
    for (int i = 0; i < 6; i++) begin
      next_cyc();
      @(negedge clk);
      chk($sformatf("rr_seq%0d_ch", i), int'(ch4), exp_seq[i]);
      chk($sformatf("rr_seq%0d_out", i), int'(out4), exp_seq[i] + 1);
      chk($sformatf("rr_seq%0d_vld", i), int'(vld4), 1);
    end

    // Asynchronous reset while a word is held.
    next_cyc();
    #2 clr = 1'b1;
    #1;
    chk("arst_out", int'(out4), 0);
    chk("arst_vld", int'(vld4), 0);
    chk("arst_ch", int'(ch4), 0);
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("post_reset_gnt", int'(gnt4), 4'b0001);
    next_cyc();
    @(negedge clk);
    chk("post_reset_ch", int'(ch4), 0);
    chk("post_reset_gnt2", int'(gnt4), 4'b0010);

    // rr_ptr is now 2; sparse requests 1010.
    next_cyc();
    req_v[0] = 5'b01010;
    @(negedge clk);
    chk("sparse_gnt0", int'(gnt4), 4'b1000);
    next_cyc();
    @(negedge clk);
    chk("sparse_gnt1", int'(gnt4), 4'b0010);
    chk("sparse_ch1", int'(ch4), 3);
    next_cyc();
    @(negedge clk);
    chk("sparse_gnt2", int'(gnt4), 4'b1000);
    chk("sparse_ch2", int'(ch4), 1);

    // Back-pressure for 3 cycles while REQ, MODE and D move around.
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      rdy_v[0] = 1'b0;
      mode_v[0] = ~mode_v[0];
      req_v[0] = 5'($urandom_range(1, 15));
      d_v[0] = 25'($urandom);
      @(negedge clk);
      chk($sformatf("bp%0d_gnt", i), int'(gnt4), 0);
      chk($sformatf("bp%0d_ch", i), int'(ch4), 3);
      chk($sformatf("bp%0d_out", i), int'(out4), 4);
      chk($sformatf("bp%0d_vld", i), int'(vld4), 1);
    end
    next_cyc();
    rdy_v[0] = 1'b1; mode_v[0] = 1'b1; req_v[0] = 5'b01111;
    d_v[0] = {5'd0, 5'd4, 5'd3, 5'd2, 5'd1};
    @(negedge clk);
    chk("bp_release_gnt", int'(gnt4), 4'b0001);
    chk("bp_release_vld", int'(vld4), 1);
    next_cyc();
    @(negedge clk);
    chk("bp_b2b_vld", int'(vld4), 1);
    chk("bp_b2b_ch", int'(ch4), 0);
    chk("bp_b2b_out", int'(out4), 1);

    // CH = 5: select values past the last channel never grant.
    for (int s = 5; s < 8; s++) begin
      next_cyc();
      mode_v[1] = 1'b0; sel_v[1] = 3'(s); req_v[1] = 5'b11111;
      en_v[1] = 1'b1; rdy_v[1] = 1'b1; d_v[1] = 25'($urandom);
      @(negedge clk);
      chk($sformatf("oob_sel%0d_gnt", s), int'(gnt5), 0);
      chk($sformatf("oob_sel%0d_vld", s), int'(vld5), 0);
    end

    // Random soak on both instances, with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      next_cyc();
      for (int u = 0; u < 2; u++) begin
        d_v[u]    = 25'($urandom);
        req_v[u]  = (u == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
        sel_v[u]  = (u == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        mode_v[u] = 1'($urandom_range(0, 1));
        en_v[u]   = ($urandom_range(0, 7) != 0);
        rdy_v[u]  = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 clr = 1'b1;
        #3 clr = 1'b0;
      end
    end

    next_cyc();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
